// File: rtl/efuse_pwr_pkg.sv
// Shared definitions for the eFuse power-switch sequencer: state encoding,
// default interval lengths and the per-state switch control patterns.
package efuse_pwr_pkg;

  localparam int unsigned DefCntW     = 8;
  localparam int unsigned DefTUnshort = 4;
  localparam int unsigned DefTEn      = 8;
  localparam int unsigned DefTRamp    = 16;
  localparam int unsigned DefTDisch   = 8;
  localparam int unsigned DefTBurnMax = 200;

  typedef enum logic [2:0] {
    StIdle,
    StUnshort,
    StEnable,
    StRamp,
    StReady,
    StRampdown,
    StDisable,
    StDischarge
  } pwr_state_e;

  typedef struct packed {
    logic sw_short;
    logic sw_en;
    logic sw_rampena;
    logic ready;
  } pwr_out_t;

  localparam pwr_out_t OutShorted = '{sw_short: 1'b1, sw_en: 1'b0, sw_rampena: 1'b0, ready: 1'b0};
  localparam pwr_out_t OutOff     = '{sw_short: 1'b0, sw_en: 1'b0, sw_rampena: 1'b0, ready: 1'b0};
  localparam pwr_out_t OutEn      = '{sw_short: 1'b0, sw_en: 1'b1, sw_rampena: 1'b0, ready: 1'b0};
  localparam pwr_out_t OutRamp    = '{sw_short: 1'b0, sw_en: 1'b1, sw_rampena: 1'b1, ready: 1'b0};
  localparam pwr_out_t OutReady   = '{sw_short: 1'b0, sw_en: 1'b1, sw_rampena: 1'b1, ready: 1'b1};

  function automatic pwr_out_t state_out(pwr_state_e s);
    pwr_out_t o;
    case (s)
      StUnshort, StDisable: o = OutOff;
      StEnable, StRampdown: o = OutEn;
      StRamp:               o = OutRamp;
      StReady:              o = OutReady;
      default:              o = OutShorted;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/efuse_pwr_timer.sv
// Loadable down-counter shared by all timed states and the READY watchdog.
// Holds at zero; expired is high whenever the count is zero.
module efuse_pwr_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/efuse_pwr_sequencer.sv
// Orders SHORT/EN/RAMPENA of the eFuse power switch on power-up and power-down,
// with abort handling and a watchdog bounding the time VDDQ_2V5 stays up.
module efuse_pwr_sequencer
  import efuse_pwr_pkg::*;
#(
  parameter int unsigned CNT_W      = DefCntW,
  parameter int unsigned T_UNSHORT  = DefTUnshort,
  parameter int unsigned T_EN       = DefTEn,
  parameter int unsigned T_RAMP     = DefTRamp,
  parameter int unsigned T_DISCH    = DefTDisch,
  parameter int unsigned T_BURN_MAX = DefTBurnMax
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  input  logic burn_done,
  input  logic abort,
  output logic EN,
  output logic RAMPENA,
  output logic SHORT,
  output logic vddq_ready,
  output logic busy,
  output logic timeout_err,
  output logic done_pulse
);

  localparam int unsigned TMax = 32'd1 << CNT_W;

  if (T_UNSHORT < 1 || T_UNSHORT > TMax || T_EN < 1 || T_EN > TMax ||
      T_RAMP < 1 || T_RAMP > TMax || T_DISCH < 1 || T_DISCH > TMax ||
      T_BURN_MAX < 1 || T_BURN_MAX > TMax) begin : g_param_check
    $error("efuse_pwr_sequencer: every T_* must lie in [1, 2**CNT_W]");
  end

  pwr_state_e       state_q, state_d;
  pwr_out_t         out_q;
  logic             busy_q, timeout_q, timeout_d, done_q;
  logic             load, expired;
  logic [CNT_W-1:0] load_val;

  efuse_pwr_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (load),
    .load_val (load_val),
    .expired  (expired)
  );

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d   = StUnshort;
          timeout_d = 1'b0;
        end
      end
      StUnshort: begin
        if (abort)        state_d = StDischarge;
        else if (expired) state_d = StEnable;
      end
      StEnable: begin
        if (abort)        state_d = StDisable;
        else if (expired) state_d = StRamp;
      end
      StRamp: begin
        if (abort)        state_d = StRampdown;
        else if (expired) state_d = StReady;
      end
      StReady: begin
        if (abort || burn_done) begin
          state_d = StRampdown;
        end else if (expired) begin
          state_d   = StRampdown;
          timeout_d = 1'b1;
        end
      end
      StRampdown:  if (expired) state_d = StDisable;
      StDisable:   if (expired) state_d = StDischarge;
      StDischarge: if (expired) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Every state change reloads the timer with the length of the state being entered.
  always_comb begin
    load = (state_d != state_q);
    case (state_d)
      StUnshort:            load_val = CNT_W'(T_UNSHORT - 1);
      StEnable, StDisable:  load_val = CNT_W'(T_EN - 1);
      StRamp, StRampdown:   load_val = CNT_W'(T_RAMP - 1);
      StReady:              load_val = CNT_W'(T_BURN_MAX - 1);
      StDischarge:          load_val = CNT_W'(T_DISCH - 1);
      default:              load_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      out_q     <= OutShorted;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= state_out(state_d);
      busy_q    <= (state_d != StIdle);
      timeout_q <= timeout_d;
      done_q    <= (state_q == StDischarge) && (state_d == StIdle);
    end
  end

  assign SHORT       = out_q.sw_short;
  assign EN          = out_q.sw_en;
  assign RAMPENA     = out_q.sw_rampena;
  assign vddq_ready  = out_q.ready;
  assign busy        = busy_q;
  assign timeout_err = timeout_q;
  assign done_pulse  = done_q;

endmodule

// File: tb/tb_efuse_pwr_sequencer.sv
// Bench for efuse_pwr_sequencer: timeline vector tables, reset cases and random
// traffic against a phase/elapsed-time reference model, on default and all-ones timing.
module tb_efuse_pwr_sequencer;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0, burn_done = 1'b0, abort = 1'b0;
  logic sh0, en0, ra0, rd0, bz0, to0, dn0;
  logic sh1, en1, ra1, rd1, bz1, to1, dn1;

  efuse_pwr_sequencer dut0 (
    .clk (clk), .rstn (rstn), .start (start), .burn_done (burn_done), .abort (abort),
    .EN (en0), .RAMPENA (ra0), .SHORT (sh0), .vddq_ready (rd0), .busy (bz0),
    .timeout_err (to0), .done_pulse (dn0)
  );

  efuse_pwr_sequencer #(
    .CNT_W (8), .T_UNSHORT (1), .T_EN (1), .T_RAMP (1), .T_DISCH (1), .T_BURN_MAX (1)
  ) dut1 (
    .clk (clk), .rstn (rstn), .start (start), .burn_done (burn_done), .abort (abort),
    .EN (en1), .RAMPENA (ra1), .SHORT (sh1), .vddq_ready (rd1), .busy (bz1),
    .timeout_err (to1), .done_pulse (dn1)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: phase index along the power-up/power-down path (0 = idle,
  // 1..4 up, 5..7 down) and edges elapsed since the phase was entered.
  int dur [2][8];
  int ph  [2];
  int age [2];
  bit mtmo[2];
  bit mdn [2];

  typedef struct {
    int       sc;
    int       at;
    bit       s;
    bit       b;
    bit       a;
    logic [6:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [6:0] act_out(int k);
    if (k == 0) return {sh0, en0, ra0, rd0, bz0, to0, dn0};
    return {sh1, en1, ra1, rd1, bz1, to1, dn1};
  endfunction

  function automatic logic [6:0] model_out(int k);
    int p = ph[k];
    return {p == 0 || p == 7, p >= 2 && p <= 5, p == 3 || p == 4, p == 4, p != 0,
            mtmo[k], mdn[k]};
  endfunction

  function automatic bit inv_ok(logic s, logic e, logic r, logic q);
    return (!r || (e && !s)) && (!e || !s) && (!q || r);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; age[k] = 0; mtmo[k] = 1'b0; mdn[k] = 1'b0;
    end
  endtask

  task automatic model_step(int k, bit s, bit b, bit a);
    int p    = ph[k];
    int nxt  = p;
    bit last = (age[k] + 1 >= dur[k][p]);
    mdn[k] = 1'b0;
    case (p)
      0: if (s && !a) begin nxt = 1; mtmo[k] = 1'b0; end
      1, 2, 3: begin
        if (a) nxt = 8 - p;
        else if (last) nxt = p + 1;
      end
      4: begin
        if (a || b) nxt = 5;
        else if (last) begin nxt = 5; mtmo[k] = 1'b1; end
      end
      5, 6: if (last) nxt = p + 1;
      default: if (last) begin nxt = 0; mdn[k] = 1'b1; end
    endcase
    age[k] = (nxt != p) ? 0 : age[k] + 1;
    ph[k]  = nxt;
  endtask

  task automatic check(string name, logic [6:0] act, logic [6:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (SHORT EN RAMPENA ready busy timeout done)",
                  name, act, exp);
  endtask

  // One clock: inputs are seen by exactly one rising edge, outputs checked 1 ns later.
  task automatic cyc(bit s, bit b, bit a);
    start = s; burn_done = b; abort = a;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, s, b, a);
    #1;
    check("model_dut0", act_out(0), model_out(0));
    check("model_dut1", act_out(1), model_out(1));
    start = 1'b0; burn_done = 1'b0; abort = 1'b0;
  endtask

  task automatic add(int sc, int at, bit s, bit b, bit a, logic [6:0] x);
    vec_t v;
    v.sc = sc; v.at = at; v.s = s; v.b = b; v.a = a; v.exp = x;
    vecs.push_back(v);
  endtask

  task automatic run_sc(int sc, string name);
    int last = 0;
    foreach (vecs[i]) if (vecs[i].sc == sc && vecs[i].at > last) last = vecs[i].at;
    for (int c = 0; c <= last; c++) begin
      int hit = -1;
      foreach (vecs[i]) if (vecs[i].sc == sc && vecs[i].at == c) hit = i;
      if (hit >= 0) begin
        cyc(vecs[hit].s, vecs[hit].b, vecs[hit].a);
        check($sformatf("%s@%0d", name, c), act_out(0), vecs[hit].exp);
      end else begin
        cyc(1'b0, 1'b0, 1'b0);
      end
    end
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    n_total++;
    if (inv_ok(sh0, en0, ra0, rd0)) n_pass++;
    else $display("FAIL invariant dut0: SHORT=%b EN=%b RAMPENA=%b ready=%b", sh0, en0, ra0, rd0);
    n_total++;
    if (inv_ok(sh1, en1, ra1, rd1)) n_pass++;
    else $display("FAIL invariant dut1: SHORT=%b EN=%b RAMPENA=%b ready=%b", sh1, en1, ra1, rd1);
  end

  initial begin
    dur[0] = '{0, 4, 8, 16, 200, 16, 8, 8};
    dur[1] = '{0, 1, 1, 1, 1, 1, 1, 1};
    model_reset();

    // Bits: SHORT EN RAMPENA ready busy timeout_err done_pulse
    add(1, 0, 1, 0, 0, 7'b0000100);  add(1, 3, 0, 0, 0, 7'b0000100);
    add(1, 4, 0, 0, 0, 7'b0100100);  add(1, 11, 0, 0, 0, 7'b0100100);
    add(1, 12, 0, 0, 0, 7'b0110100); add(1, 27, 0, 0, 0, 7'b0110100);
    add(1, 28, 0, 0, 0, 7'b0111100); add(1, 40, 0, 1, 0, 7'b0100100);
    add(1, 55, 0, 0, 0, 7'b0100100); add(1, 56, 0, 0, 0, 7'b0000100);
    add(1, 64, 0, 0, 0, 7'b1000100); add(1, 71, 0, 0, 0, 7'b1000100);
    add(1, 72, 0, 0, 0, 7'b1000001); add(1, 73, 0, 0, 0, 7'b1000000);

    add(2, 0, 1, 0, 0, 7'b0000100);   add(2, 28, 0, 0, 0, 7'b0111100);
    add(2, 227, 0, 0, 0, 7'b0111100); add(2, 228, 0, 0, 0, 7'b0100110);
    add(2, 243, 0, 0, 0, 7'b0100110); add(2, 244, 0, 0, 0, 7'b0000110);
    add(2, 252, 0, 0, 0, 7'b1000110); add(2, 260, 0, 0, 0, 7'b1000011);
    add(2, 262, 1, 0, 0, 7'b0000100); add(2, 263, 0, 0, 1, 7'b1000100);
    add(2, 271, 0, 0, 0, 7'b1000001);

    add(3, 0, 1, 0, 0, 7'b0000100);  add(3, 6, 0, 0, 1, 7'b0000100);
    add(3, 14, 0, 0, 0, 7'b1000100); add(3, 22, 0, 0, 0, 7'b1000001);

    add(4, 0, 1, 0, 0, 7'b0000100);  add(4, 2, 0, 0, 1, 7'b1000100);
    add(4, 9, 0, 0, 0, 7'b1000100);  add(4, 10, 0, 0, 0, 7'b1000001);

    add(5, 0, 1, 0, 0, 7'b0000100);  add(5, 30, 0, 1, 1, 7'b0100100);
    add(5, 62, 0, 0, 0, 7'b1000001);

    add(6, 0, 1, 0, 0, 7'b0000100);  add(6, 30, 1, 0, 0, 7'b0111100);
    add(6, 40, 0, 1, 0, 7'b0100100); add(6, 60, 1, 0, 0, 7'b0000100);
    add(6, 72, 0, 0, 0, 7'b1000001); add(6, 73, 0, 0, 0, 7'b1000000);

    add(7, 0, 1, 0, 1, 7'b1000000);  add(7, 1, 0, 0, 0, 7'b1000000);

    repeat (3) @(posedge clk);
    #1;
    check("reset_dut0", act_out(0), 7'b1000000);
    check("reset_dut1", act_out(1), 7'b1000000);
    rstn = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    run_sc(1, "normal");
    run_sc(2, "watchdog");
    run_sc(3, "abort_enable");
    run_sc(4, "abort_unshort");
    run_sc(5, "abort_burn_ready");
    run_sc(6, "start_while_busy");
    run_sc(7, "start_abort_idle");

    // Asynchronous reset while in READY, then a full normal cycle.
    cyc(1'b1, 1'b0, 1'b0);
    repeat (30) cyc(1'b0, 1'b0, 1'b0);
    check("pre_reset_ready", act_out(0), 7'b0111100);
    #2 rstn = 1'b0;
    #1;
    check("async_reset_dut0", act_out(0), 7'b1000000);
    check("async_reset_dut1", act_out(1), 7'b1000000);
    model_reset();
    @(posedge clk);
    #1 rstn = 1'b1;
    run_sc(1, "after_reset");

    repeat (3000)
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0);
    repeat (300) cyc(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/efuse_pwr_sequencer.md
Name: efuse_pwr_sequencer

Overview:
Digital controller directly upstream of the eFuse power switch. It generates that switch's EN, RAMPENA and SHORT controls.
- Ordered power-up: release SHORT, then assert EN, then assert RAMPENA, then flag VDDQ_2V5 ready to the programming engine.
- Power-down mirrors it and ends with the output shorted to ground.
- Includes an abort path and a burn-window watchdog so VDDQ_2V5 is never left up indefinitely.

Parameters:
- CNT_W, 8, width of the shared interval down-counter.
- T_UNSHORT, 4, cycles between SHORT release and EN assertion.
- T_EN, 8, cycles between EN and RAMPENA on power-up; also cycles between EN drop and SHORT assertion on power-down.
- T_RAMP, 16, cycles between RAMPENA and vddq_ready on power-up; also cycles between RAMPENA drop and EN drop on power-down.
- T_DISCH, 8, cycles SHORT is held before returning to idle.
- T_BURN_MAX, 200, maximum cycles allowed in READY before a forced power-down.
- Constraint: every T_* satisfies 1 <= T <= 2^CNT_W (elaboration check).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  power-up request; honoured only in IDLE.
- burn_done  in  1  from programming engine: burn complete; honoured only in READY.
- abort  in  1  immediate orderly power-down request.
- EN  out  1  to power switch EN.
- RAMPENA  out  1  to power switch RAMPENA.
- SHORT  out  1  to power switch SHORT.
- vddq_ready  out  1  VDDQ_2V5 stable; engine may burn.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky watchdog flag.
- done_pulse  out  1  one-cycle pulse on return to IDLE.

Behaviour:
- Reset is asynchronous and active-low.
  - While rstn=0: state=IDLE, SHORT=1, EN=0, RAMPENA=0, vddq_ready=0, busy=0, timeout_err=0, done_pulse=0, counter=0.
  - Reset asserted mid-operation forces this safe state immediately, without waiting for a clock edge.
- All outputs are flops updated on the same edge as the state register; no combinational decode reaches the switch.
- Timed states load counter=T-1 on entry and leave on the edge where counter==0, so each lasts exactly T cycles.
- States, with outputs listed as SHORT/EN/RAMPENA/ready:
  - IDLE 1/0/0/0. start=1 and abort=0 -> UNSHORT, and timeout_err clears.
  - UNSHORT 0/0/0/0, T_UNSHORT -> ENABLE. abort -> DISCHARGE.
  - ENABLE 0/1/0/0, T_EN -> RAMP. abort -> DISABLE.
  - RAMP 0/1/1/0, T_RAMP -> READY. abort -> RAMPDOWN.
  - READY 0/1/1/1. Exits:
    - burn_done or abort -> RAMPDOWN.
    - T_BURN_MAX cycles without either -> RAMPDOWN, with timeout_err=1.
  - RAMPDOWN 0/1/0/0, T_RAMP -> DISABLE.
  - DISABLE 0/0/0/0, T_EN -> DISCHARGE.
  - DISCHARGE 1/0/0/0, T_DISCH -> IDLE. done_pulse=1 on the entry edge into IDLE.
- Abort has priority over burn_done and over the watchdog.
  - abort+burn_done together in READY -> RAMPDOWN, timeout_err unchanged.
  - abort in RAMPDOWN, DISABLE or DISCHARGE is ignored; the sequence completes normally.
- start while busy is ignored (not queued). start+abort together in IDLE: remain in IDLE.
- burn_done outside READY is ignored.
- timeout_err holds until the next accepted start.
- Invariants, required every cycle:
  - RAMPENA -> EN & !SHORT.
  - EN -> !SHORT.
  - vddq_ready -> RAMPENA.
- Latency with defaults, measured from the start edge (edge 0): EN at edge 4, RAMPENA at edge 12, vddq_ready at edge 28.

Decomposition:
- Shared package efuse_pwr_pkg holds:
  - state encoding: IDLE, UNSHORT, ENABLE, RAMP, READY, RAMPDOWN, DISABLE, DISCHARGE;
  - default T_* constants;
  - the per-state output-pattern constants.
- One sub-module, efuse_pwr_timer: load value, load strobe, down-count, expire flag, CNT_W wide. It is reused for the READY watchdog count.

Test Plan:
- Normal cycle, defaults. Stimulus: start at edge 0, burn_done at edge 40. Required:
  - SHORT falls edge 0, EN rises 4, RAMPENA rises 12, vddq_ready rises 28;
  - RAMPENA and ready fall 40, EN falls 56, SHORT rises 64;
  - IDLE, busy=0 and done_pulse at 72.
- Watchdog. Stimulus: start at 0, burn_done never asserted. Required:
  - ready 28 -> 228: RAMPENA falls and timeout_err=1;
  - EN falls 244, SHORT rises 252, IDLE at 260;
  - next start clears timeout_err.
- Abort in ENABLE. Stimulus: abort at edge 6. Required: EN falls 6, SHORT rises 14, IDLE 22; RAMPENA never asserted. Same check for abort in UNSHORT at edge 2: SHORT rises 2, IDLE 10.
- Simultaneous events:
  - abort+burn_done in READY -> RAMPDOWN, timeout_err=0;
  - start pulses at edges 30 and 60 (busy) -> ignored, exactly one done_pulse;
  - start+abort in IDLE -> stays IDLE.
- Reset mid-READY: rstn low between clock edges -> SHORT=1, EN=0, RAMPENA=0, ready=0 immediately. After release, start gives a full normal cycle.
- Assertion checker for all invariants runs across every scenario, including with all T_* set to 1.
